// File: rtl/invader_formation_pkg.sv
// Shared constants, state encoding and bounds record for the alien formation.
// Default formation geometry and screen limits live here so the VGA side can share them.
package invader_formation_pkg;

  localparam int INVADERS_H = 11;
  localparam int INVADERS_V = 5;
  localparam int N_INVADERS = INVADERS_H * INVADERS_V;
  localparam int OFFSET_H   = 40;
  localparam int OFFSET_V   = 32;
  localparam int INV_W      = 24;
  localparam int INV_H      = 16;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int MIN_X      = 8;
  localparam int MAX_X      = 632;
  localparam int BOTTOM_Y   = 420;

  // One bit wider than any screen coordinate so edge sums cannot wrap.
  localparam int COORD_W    = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MARCH  = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_LANDED = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] left;
    logic [3:0] right;
    logic [2:0] bottom;
  } bounds_t;

endpackage

// File: rtl/invader_formation_bounds.sv
// Combinational extent of the live formation: leftmost/rightmost live column
// and lowest live row, all 0-based. An empty mask reports all zeros.
module invader_bounds
  import invader_formation_pkg::*;
#(
  parameter int COLS = 11,
  parameter int ROWS = 5
) (
  input  logic [COLS*ROWS-1:0] mask,
  output bounds_t              bounds
);

  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    col_any = '0;
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_any[c] = col_any[c] | mask[r*COLS+c];
        row_any[r] = row_any[r] | mask[r*COLS+c];
      end
    end
  end

  // Scan direction decides which set bit wins: last assignment is the answer.
  always_comb begin
    bounds = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_any[c]) bounds.left = 4'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (col_any[c]) bounds.right = 4'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (row_any[r]) bounds.bottom = 3'(r);
    end
  end

endmodule

// File: rtl/invader_formation.sv
// Alien formation state owner: alive mask, origin, per-frame march, kills, clear/landing.
// Define INVADER_SPEEDUP_EN to make the step period shrink as invaders die.
module invader_formation
  import invader_formation_pkg::*;
#(
  parameter int INVADERS_H = invader_formation_pkg::INVADERS_H,
  parameter int INVADERS_V = invader_formation_pkg::INVADERS_V,
  parameter int OFFSET_H   = invader_formation_pkg::OFFSET_H,
  parameter int OFFSET_V   = invader_formation_pkg::OFFSET_V,
  parameter int INV_W      = invader_formation_pkg::INV_W,
  parameter int INV_H      = invader_formation_pkg::INV_H,
  parameter int START_X    = 100,
  parameter int START_Y    = 40,
  parameter int STEP_X     = 2,
  parameter int STEP_Y     = 8,
  parameter int MIN_X      = invader_formation_pkg::MIN_X,
  parameter int MAX_X      = invader_formation_pkg::MAX_X,
  parameter int BOTTOM_Y   = invader_formation_pkg::BOTTOM_Y,
  parameter int PERIOD_MAX = 28
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             frame,
  input  logic                             start,
  input  logic [5:0]                       invader_collision,
  output logic [INVADERS_H*INVADERS_V-1:0] invaders,
  output logic [9:0]                       invaders_x,
  output logic [9:0]                       invaders_y,
  output logic                             dir_left,
  output logic                             kill,
  output logic [5:0]                       alive_cnt,
  output logic                             wave_clear,
  output logic                             landed
);

  localparam int N_CELLS = INVADERS_H * INVADERS_V;
  localparam int CW      = COORD_W;

  state_e               state_q, state_d;
  logic [N_CELLS-1:0]   invaders_q, invaders_d;
  logic [9:0]           x_q, x_d, y_q, y_d;
  logic                 dir_left_q, dir_left_d;
  logic                 kill_q, kill_d;
  logic [5:0]           alive_cnt_q, alive_cnt_d;
  logic                 wave_clear_q, wave_clear_d;
  logic                 landed_q, landed_d;
  logic [4:0]           frame_cnt_q, frame_cnt_d;

  bounds_t              bnd;
  logic [4:0]           period_m1;
  logic                 marching, step_tick, kill_hit, at_edge, lands;
  logic [5:0]           coll_idx;
  logic [N_CELLS-1:0]   coll_mask;
  logic [CW-1:0]        right_edge, left_edge, bottom_edge;
  logic [9:0]           x_step, y_tick;

  invader_bounds #(
    .COLS (INVADERS_H),
    .ROWS (INVADERS_V)
  ) u_bounds (
    .mask   (invaders_q),
    .bounds (bnd)
  );

`ifdef INVADER_SPEEDUP_EN
  // P - 1 = alive_cnt >> 1, so the compare needs no adder.
  assign period_m1 = alive_cnt_q[5:1];
`else
  assign period_m1 = 5'(PERIOD_MAX - 1);
`endif

  assign marching  = (state_q == ST_MARCH);
  // >= rather than == so a period that shrank under the counter ticks on the next frame.
  assign step_tick = marching && frame && (frame_cnt_q >= period_m1);

  assign coll_idx  = invader_collision - 6'd1;
  assign coll_mask = ((invader_collision != 6'd0) && (invader_collision <= 6'(N_CELLS)))
                     ? (N_CELLS'(1) << coll_idx) : '0;
  assign kill_hit  = marching && |(invaders_q & coll_mask);

  // Edge and landing tests use the pre-kill mask, which is what the bounds see this cycle.
  assign right_edge  = CW'(x_q) + CW'(bnd.right) * CW'(OFFSET_H) + CW'(INV_W + STEP_X);
  assign left_edge   = CW'(x_q) + CW'(bnd.left) * CW'(OFFSET_H);
  assign at_edge     = dir_left_q ? (left_edge < CW'(MIN_X + STEP_X))
                                  : (right_edge > CW'(MAX_X));
  assign x_step      = dir_left_q ? (x_q - 10'(STEP_X)) : (x_q + 10'(STEP_X));
  assign y_tick      = at_edge ? (y_q + 10'(STEP_Y)) : y_q;
  assign bottom_edge = CW'(y_tick) + CW'(bnd.bottom) * CW'(OFFSET_V) + CW'(INV_H);
  assign lands       = bottom_edge >= CW'(BOTTOM_Y);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Clearing the wave wins over landing when the last kill and a landing tick coincide.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_MARCH;
    end else if (marching) begin
      if (kill_hit && (alive_cnt_q == 6'd1)) state_d = ST_CLEAR;
      else if (step_tick && lands)           state_d = ST_LANDED;
    end
  end

  always_comb begin
    invaders_d   = invaders_q;
    alive_cnt_d  = alive_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_left_d   = dir_left_q;
    frame_cnt_d  = frame_cnt_q;
    kill_d       = 1'b0;
    wave_clear_d = (state_d == ST_CLEAR);
    landed_d     = (state_d == ST_LANDED);
    if (start) begin
      invaders_d  = '1;
      alive_cnt_d = 6'(N_CELLS);
      x_d         = 10'(START_X);
      y_d         = 10'(START_Y);
      dir_left_d  = 1'b0;
      frame_cnt_d = '0;
    end else if (marching) begin
      if (frame) frame_cnt_d = step_tick ? 5'd0 : (frame_cnt_q + 5'd1);
      if (step_tick) begin
        if (at_edge) begin
          y_d        = y_tick;
          dir_left_d = ~dir_left_q;
        end else begin
          x_d = x_step;
        end
      end
      if (kill_hit) begin
        invaders_d  = invaders_q & ~coll_mask;
        alive_cnt_d = alive_cnt_q - 6'd1;
        kill_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invaders_q   <= '0;
      alive_cnt_q  <= '0;
      x_q          <= 10'(START_X);
      y_q          <= 10'(START_Y);
      dir_left_q   <= 1'b0;
      kill_q       <= 1'b0;
      wave_clear_q <= 1'b0;
      landed_q     <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      invaders_q   <= invaders_d;
      alive_cnt_q  <= alive_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_left_q   <= dir_left_d;
      kill_q       <= kill_d;
      wave_clear_q <= wave_clear_d;
      landed_q     <= landed_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign invaders   = invaders_q;
  assign invaders_x = x_q;
  assign invaders_y = y_q;
  assign dir_left   = dir_left_q;
  assign kill       = kill_q;
  assign alive_cnt  = alive_cnt_q;
  assign wave_clear = wave_clear_q;
  assign landed     = landed_q;

endmodule

// File: tb/tb_invader_formation.sv
// Self-checking bench for invader_formation: behavioural model compared every cycle,
// directed scenarios pinned with literals, then randomized stimulus. Honors INVADER_SPEEDUP_EN.
module tb_invader_formation;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  invader_collision = 6'd0;

  logic [54:0] invaders;
  logic [9:0]  invaders_x, invaders_y;
  logic        dir_left, kill, wave_clear, landed;
  logic [5:0]  alive_cnt;

  logic [54:0] f_invaders;
  logic [9:0]  f_x, f_y;
  logic        f_dir_left, f_kill, f_wave_clear, f_landed;
  logic [5:0]  f_alive_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  invader_formation dut (
    .clk (clk), .rst_n (rst_n), .frame (frame), .start (start),
    .invader_collision (invader_collision),
    .invaders (invaders), .invaders_x (invaders_x), .invaders_y (invaders_y),
    .dir_left (dir_left), .kill (kill), .alive_cnt (alive_cnt),
    .wave_clear (wave_clear), .landed (landed)
  );

  // Same design with a one-frame step period so a full descent fits in a short run.
  invader_formation #(.PERIOD_MAX(1)) u_fast (
    .clk (clk), .rst_n (rst_n), .frame (frame), .start (start),
    .invader_collision (invader_collision),
    .invaders (f_invaders), .invaders_x (f_x), .invaders_y (f_y),
    .dir_left (f_dir_left), .kill (f_kill), .alive_cnt (f_alive_cnt),
    .wave_clear (f_wave_clear), .landed (f_landed)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_MARCH = 1, M_CLEAR = 2, M_LANDED = 3;

  bit m_alive[55];
  int m_x, m_y, m_state, m_fc;
  bit m_left, m_kill;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 55; i++) n += int'(m_alive[i]);
    return n;
  endfunction

  function automatic logic [54:0] m_mask();
    logic [54:0] m = '0;
    for (int i = 0; i < 55; i++) m[i] = m_alive[i];
    return m;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 55; i++) m_alive[i] = 1'b0;
    m_x = 100; m_y = 40; m_state = M_IDLE; m_fc = 0; m_left = 1'b0; m_kill = 1'b0;
  endtask

  task automatic m_step(input bit st, input bit fr, input int col);
    int  n, period, lc, rc, br;
    bit  tick, hit, lands;
    m_kill = 1'b0;
    if (st) begin
      for (int i = 0; i < 55; i++) m_alive[i] = 1'b1;
      m_x = 100; m_y = 40; m_left = 1'b0; m_fc = 0; m_state = M_MARCH;
      return;
    end
    if (m_state != M_MARCH) return;
    n = m_count();
`ifdef INVADER_SPEEDUP_EN
    period = 1 + n / 2;
`else
    period = 28;
`endif
    tick = 1'b0;
    if (fr) begin
      if (m_fc + 1 >= period) begin m_fc = 0; tick = 1'b1; end
      else m_fc++;
    end
    lc = 10; rc = 0; br = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 11; c++)
        if (m_alive[r*11+c]) begin
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > br) br = r;
        end
    lands = 1'b0;
    if (tick) begin
      if ((!m_left && (m_x + rc*40 + 24 + 2 > 632)) || (m_left && (m_x + lc*40 < 8 + 2))) begin
        m_y += 8;
        m_left = !m_left;
      end else begin
        m_x += m_left ? -2 : 2;
      end
      lands = (m_y + br*32 + 16 >= 420);
    end
    hit = (col >= 1) && (col <= 55) && m_alive[col-1];
    if (hit) begin
      m_alive[col-1] = 1'b0;
      m_kill = 1'b1;
    end
    if (hit && n == 1) m_state = M_CLEAR;
    else if (lands)    m_state = M_LANDED;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step(start, frame, int'(invader_collision));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_invaders",   invaders,   m_mask());
      check("cyc_x",          invaders_x, 64'(m_x));
      check("cyc_y",          invaders_y, 64'(m_y));
      check("cyc_dir_left",   dir_left,   64'(m_left));
      check("cyc_kill",       kill,       64'(m_kill));
      check("cyc_alive_cnt",  alive_cnt,  64'(m_count()));
      check("cyc_wave_clear", wave_clear, 64'(m_state == M_CLEAR));
      check("cyc_landed",     landed,     64'(m_state == M_LANDED));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame = 1'b1; cyc(); frame = 1'b0; cyc();
    end
  endtask

  initial begin
    int  kills;
    bit  landed_seen;

    repeat (3) cyc();
    check("rst_invaders", invaders, 64'd0);
    check("rst_x", invaders_x, 64'd100);
    check("rst_y", invaders_y, 64'd40);
    check("rst_alive", alive_cnt, 64'd0);
    check("rst_flags", {dir_left, kill, wave_clear, landed}, 64'd0);
    rst_n = 1'b1;
    cyc();

    pulse_start();
    check("start_mask", invaders, 64'h7F_FFFF_FFFF_FFFF);
    check("start_x", invaders_x, 64'd100);
    check("start_y", invaders_y, 64'd40);
    check("start_alive", alive_cnt, 64'd55);
    check("start_dir", dir_left, 64'd0);

    // Held collision kills exactly once; out-of-range index does nothing.
    invader_collision = 6'd1;
    kills = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      kills += int'(kill);
      if (i == 0) begin
        check("kill1_bit0", invaders[0], 64'd0);
        check("kill1_alive", alive_cnt, 64'd54);
        check("kill1_pulse", kill, 64'd1);
      end
    end
    check("kill1_pulses", 64'(kills), 64'd1);
    invader_collision = 6'd60;
    repeat (3) cyc();
    invader_collision = 6'd0;
    check("kill60_alive", alive_cnt, 64'd54);
    check("kill60_mask", invaders, 64'h7F_FFFF_FFFF_FFFE);

    // Step period 28 with 55 alive, then march to the right edge.
    pulse_start();
    frames(27);
    check("p27_x", invaders_x, 64'd100);
    frames(1);
    check("p28_x", invaders_x, 64'd102);
    frames(53 * 28);
    // At x=206 the edge sum is 206+400+24+2=632, not above 632, so one more step to 208.
    check("edge_x", invaders_x, 64'd208);
    check("edge_y", invaders_y, 64'd40);
    frames(28);
    check("drop_y", invaders_y, 64'd48);
    check("drop_x", invaders_x, 64'd208);
    check("drop_dir", dir_left, 64'd1);
    frames(28);
    check("left_x", invaders_x, 64'd206);

    // Kill every invader; motion stops until the next start.
    pulse_start();
    for (int i = 1; i <= 55; i++) begin
      invader_collision = 6'(i);
      cyc();
    end
    invader_collision = 6'd0;
    check("clear_flag", wave_clear, 64'd1);
    check("clear_alive", alive_cnt, 64'd0);
    check("clear_mask", invaders, 64'd0);
    frames(30);
    check("clear_x", invaders_x, 64'd100);
    check("clear_y", invaders_y, 64'd40);
    pulse_start();
    check("restart_flag", wave_clear, 64'd0);
    check("restart_mask", invaders, 64'h7F_FFFF_FFFF_FFFF);

    // Bottom row only: the fast instance descends until y+4*32+16 >= 420, i.e. y=280.
    pulse_start();
    for (int i = 1; i <= 44; i++) begin
      invader_collision = 6'(i);
      cyc();
    end
    invader_collision = 6'd0;
    check("land_alive", f_alive_cnt, 64'd11);
    frame = 1'b1;
    landed_seen = 1'b0;
    for (int i = 0; i < 40000 && !landed_seen; i++) begin
      cyc();
      if (f_landed === 1'b1) landed_seen = 1'b1;
    end
    check("land_reached", 64'(landed_seen), 64'd1);
    check("land_y", f_y, 64'd280);
    repeat (20) cyc();
    frame = 1'b0;
    check("land_hold_y", f_y, 64'd280);
    check("land_hold_flag", f_landed, 64'd1);

    // Randomized traffic with a mid-run asynchronous reset.
    pulse_start();
    for (int i = 0; i < 6000; i++) begin
      frame = (($urandom % 3) == 0);
      invader_collision = (($urandom % 6) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      start = (($urandom % 700) == 0);
      if (i == 3000) rst_n = 1'b0;
      if (i == 3002) rst_n = 1'b1;
      if (i == 3003) start = 1'b1;
      cyc();
    end
    start = 1'b0; frame = 1'b0; invader_collision = 6'd0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
